// File: rtl/gb_sprite_pkg.sv
// Shared types for the sprite fetch path: fetch FSM states, the per-pixel
// shifter slot, and the bitplane bit-select helper used for X-flip.
package gb_sprite_pkg;

    localparam int SLOT_COUNT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_LO,
        ST_RD_HI,
        ST_MERGE,
        ST_DONE
    } fetch_state_e;

    typedef struct packed {
        logic [1:0] pix;
        logic [2:0] pal_gbc;
        logic       pal_dmg;
        logic       bg_prio;
    } sprite_slot_t;

    localparam int SLOT_W = $bits(sprite_slot_t);

    // Bitplane bit feeding slot 'slot': MSB is the leftmost pixel unless X-flipped.
    function automatic logic [2:0] pixel_bit(input logic xflip, input logic [2:0] slot);
        return xflip ? slot : (3'd7 - slot);
    endfunction

endpackage

// File: rtl/sprite_row_merge.sv
// Combinational merge of one fetched sprite row into the 8-slot shifter.
// Earlier sprites keep precedence: a slot only takes the new pixel when it is
// currently transparent and the new pixel is opaque.
module sprite_row_merge
    import gb_sprite_pkg::*;
(
    input  logic [SLOT_COUNT*SLOT_W-1:0] slots_i,
    input  logic [7:0]                   lo_i,
    input  logic [7:0]                   hi_i,
    input  logic [7:0]                   attr_i,
    output logic [SLOT_COUNT*SLOT_W-1:0] slots_o
);

    // Y-flip (bit 6) is resolved upstream in the row address; VRAM bank (bit 3)
    // is consumed by the fetcher, not by the merge.
    logic unused_attr;
    assign unused_attr = ^{attr_i[6], attr_i[3]};

    for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_slot
        sprite_slot_t cur;
        sprite_slot_t fresh;
        logic [2:0]   bsel;
        logic [1:0]   new_pix;

        assign cur     = sprite_slot_t'(slots_i[g*SLOT_W +: SLOT_W]);
        assign bsel    = pixel_bit(attr_i[5], 3'(g));
        assign new_pix = {hi_i[bsel], lo_i[bsel]};
        assign fresh   = '{pix: new_pix, pal_gbc: attr_i[2:0], pal_dmg: attr_i[4], bg_prio: attr_i[7]};
        assign slots_o[g*SLOT_W +: SLOT_W] =
            ((cur.pix == 2'b00) && (new_pix != 2'b00)) ? fresh : cur;
    end

endmodule

// File: rtl/sprite_pixel_fetcher.sv
// Sprite pixel fetcher: on request from the OAM select stage, waits for the
// attributes to settle, reads both bitplane bytes of the sprite row from VRAM,
// merges them into the 8-slot pixel shifter and pulses done upstream.
// Slot 0 drives the mixer-facing pixel outputs.
module sprite_pixel_fetcher
    import gb_sprite_pkg::*;
#(
    parameter logic [12:0] TILE_BASE = 13'h0000,
    parameter int          ATTR_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        isGBC,
    input  logic        line_clear,
    input  logic        sprite_fetch,
    input  logic [10:0] sprite_addr,
    input  logic [7:0]  sprite_attr,
    output logic        sprite_fetch_done,
    output logic        vram_rd,
    output logic [12:0] vram_addr,
    output logic        vram_bank,
    input  logic [7:0]  vram_data,
    input  logic        shift,
    output logic [1:0]  spr_pix,
    output logic [2:0]  spr_pal_gbc,
    output logic        spr_pal_dmg,
    output logic        spr_bg_prio
);

    // WAIT is left on the cycle whose incremented count reaches ATTR_WAIT-1.
    localparam logic [3:0] WAIT_LAST = (ATTR_WAIT > 1) ? 4'(ATTR_WAIT - 2) : 4'd0;

    fetch_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [7:0]   attr_q, attr_d;
    logic [10:0]  addr_q, addr_d;
    logic [7:0]   lo_q, lo_d;
    logic [7:0]   hi_q, hi_d;
    logic [SLOT_COUNT*SLOT_W-1:0] slots_q, slots_d, merged;
    sprite_slot_t slot0;

    sprite_row_merge u_merge (
        .slots_i (slots_q),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .attr_i  (attr_q),
        .slots_o (merged)
    );

    // Next-state, datapath capture and VRAM/done outputs; all advances gated by ce.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        attr_d            = attr_q;
        addr_d            = addr_q;
        lo_d              = lo_q;
        hi_d              = hi_q;
        slots_d           = slots_q;
        sprite_fetch_done = 1'b0;
        vram_rd           = 1'b0;
        vram_addr         = 13'h0000;
        vram_bank         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ce && shift) begin
                    slots_d = {{SLOT_W{1'b0}}, slots_q[SLOT_COUNT*SLOT_W-1:SLOT_W]};
                end
                if (ce && sprite_fetch) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (ce) begin
                    if (!sprite_fetch) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == WAIT_LAST) begin
                            attr_d  = sprite_attr;
                            addr_d  = sprite_addr;
                            state_d = ST_RD_LO;
                        end
                    end
                end
            end
            ST_RD_LO: begin
                vram_rd   = 1'b1;
                vram_addr = TILE_BASE + {1'b0, addr_q, 1'b0};
                vram_bank = isGBC & attr_q[3];
                if (ce) begin
                    state_d = sprite_fetch ? ST_RD_HI : ST_IDLE;
                end
            end
            ST_RD_HI: begin
                vram_rd   = 1'b1;
                vram_addr = TILE_BASE + {1'b0, addr_q, 1'b1};
                vram_bank = isGBC & attr_q[3];
                if (ce) begin
                    lo_d    = vram_data;
                    state_d = sprite_fetch ? ST_MERGE : ST_IDLE;
                end
            end
            ST_MERGE: begin
                if (ce) begin
                    hi_d    = vram_data;
                    state_d = sprite_fetch ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                sprite_fetch_done = 1'b1;
                if (ce) begin
                    slots_d = merged;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and shifter registers; line_clear flushes even while ce is stopped (LCD off).
    always_ff @(posedge clk) begin
        if (reset || line_clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            slots_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
        end
    end

    // Fetch datapath registers; only meaningful once written during a fetch.
    always_ff @(posedge clk) begin
        attr_q <= attr_d;
        addr_q <= addr_d;
        lo_q   <= lo_d;
        hi_q   <= hi_d;
    end

    assign slot0       = sprite_slot_t'(slots_q[SLOT_W-1:0]);
    assign spr_pix     = slot0.pix;
    assign spr_pal_gbc = slot0.pal_gbc;
    assign spr_pal_dmg = slot0.pal_dmg;
    assign spr_bg_prio = slot0.bg_prio;

endmodule

// File: tb/tb_sprite_pixel_fetcher.sv
// Scoreboard bench for sprite_pixel_fetcher: stimulus pushes expected VRAM
// reads, done pulses and shifted-out pixels into queues; a monitor pops and
// compares whenever the DUT reads VRAM, pulses done, or a pixel is shifted out.
module tb_sprite_pixel_fetcher;

    logic        clk = 1'b0;
    logic        reset, ce, isGBC, line_clear, sprite_fetch, shift;
    logic [10:0] sprite_addr;
    logic [7:0]  sprite_attr;
    logic [7:0]  vram_data = 8'h00;
    logic        sprite_fetch_done, vram_rd, vram_bank;
    logic [12:0] vram_addr;
    logic [1:0]  spr_pix;
    logic [2:0]  spr_pal_gbc;
    logic        spr_pal_dmg, spr_bg_prio;

    always #5 clk = ~clk;

    sprite_pixel_fetcher dut (
        .clk               (clk),
        .reset             (reset),
        .ce                (ce),
        .isGBC             (isGBC),
        .line_clear        (line_clear),
        .sprite_fetch      (sprite_fetch),
        .sprite_addr       (sprite_addr),
        .sprite_attr       (sprite_attr),
        .sprite_fetch_done (sprite_fetch_done),
        .vram_rd           (vram_rd),
        .vram_addr         (vram_addr),
        .vram_bank         (vram_bank),
        .vram_data         (vram_data),
        .shift             (shift),
        .spr_pix           (spr_pix),
        .spr_pal_gbc       (spr_pal_gbc),
        .spr_pal_dmg       (spr_pal_dmg),
        .spr_bg_prio       (spr_bg_prio)
    );

    // VRAM model: data for a read strobed on one ce cycle appears on the next.
    logic [7:0] vram [0:8191];
    always @(posedge clk) if (ce && vram_rd) vram_data <= vram[vram_addr];

    int cyc = 0;
    always @(posedge clk) if (ce) cyc <= cyc + 1;

    typedef struct {
        string      tag;
        logic [1:0] pix;
        logic [2:0] gbc;
        logic       dmg;
        logic       prio;
    } pix_exp_t;

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic        bank;
    } rd_exp_t;

    pix_exp_t pix_q[$];
    rd_exp_t  rd_q[$];
    int       done_q[$];
    string    probe_tag = "";
    logic     probe = 1'b0;
    logic     finish_req = 1'b0;
    logic     ce_alt = 1'b0;
    int       n_cmp = 0;
    int       n_bad = 0;

    always @(negedge clk) begin : monitor
        pix_exp_t pe;
        rd_exp_t  re;
        int       de;
        if (ce && shift) begin
            n_cmp++;
            if (pix_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_shift: pix=%0d at ce cycle %0d, required no shift", spr_pix, cyc);
            end else begin
                pe = pix_q.pop_front();
                if (spr_pix !== pe.pix || spr_pal_gbc !== pe.gbc || spr_pal_dmg !== pe.dmg || spr_bg_prio !== pe.prio) begin
                    n_bad++;
                    $display("FAIL %s: pix=%0d gbc=%0d dmg=%0d prio=%0d, required pix=%0d gbc=%0d dmg=%0d prio=%0d",
                             pe.tag, spr_pix, spr_pal_gbc, spr_pal_dmg, spr_bg_prio, pe.pix, pe.gbc, pe.dmg, pe.prio);
                end
            end
        end
        if (ce && vram_rd) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: addr=%h at ce cycle %0d, required no read", vram_addr, cyc);
            end else begin
                re = rd_q.pop_front();
                if (cyc != re.cyc || vram_addr !== re.addr || vram_bank !== re.bank) begin
                    n_bad++;
                    $display("FAIL vram_read: cycle=%0d addr=%h bank=%0d, required cycle=%0d addr=%h bank=%0d",
                             cyc, vram_addr, vram_bank, re.cyc, re.addr, re.bank);
                end
            end
        end
        if (ce && sprite_fetch_done) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: done at ce cycle %0d, required no done", cyc);
            end else begin
                de = done_q.pop_front();
                if (cyc != de) begin
                    n_bad++;
                    $display("FAIL done_timing: done at ce cycle %0d, required %0d", cyc, de);
                end
            end
        end
        if (probe) begin
            n_cmp++;
            if ({vram_rd, vram_addr, vram_bank, sprite_fetch_done, spr_pix, spr_pal_gbc, spr_pal_dmg, spr_bg_prio} !== 23'd0) begin
                n_bad++;
                $display("FAIL %s: rd=%0d addr=%h bank=%0d done=%0d pix=%0d gbc=%0d dmg=%0d prio=%0d, required all 0",
                         probe_tag, vram_rd, vram_addr, vram_bank, sprite_fetch_done, spr_pix, spr_pal_gbc, spr_pal_dmg, spr_bg_prio);
            end
        end
        if (finish_req) begin
            n_cmp++;
            if (pix_q.size() != 0) begin
                n_bad++;
                $display("FAIL pixels_left: %0d pending, required 0", pix_q.size());
            end
            n_cmp++;
            if (rd_q.size() != 0) begin
                n_bad++;
                $display("FAIL reads_left: %0d pending, required 0", rd_q.size());
            end
            n_cmp++;
            if (done_q.size() != 0) begin
                n_bad++;
                $display("FAIL dones_left: %0d pending, required 0", done_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required self-termination");
        $fatal(1, "watchdog expired");
    end

    // Advance exactly one ce cycle; in alternating mode ce toggles each clock.
    task automatic tick();
        logic c;
        do begin
            c = ce;
            @(posedge clk);
            #1;
            ce = ce_alt ? ~ce : 1'b1;
        end while (!c);
    endtask

    task automatic push_pix(input string tag, input logic [1:0] p, input logic [2:0] g, input logic d, input logic r);
        pix_exp_t e;
        e.tag = tag; e.pix = p; e.gbc = g; e.dmg = d; e.prio = r;
        pix_q.push_back(e);
    endtask

    task automatic push_rd(input int c, input logic [12:0] a, input logic b);
        rd_exp_t e;
        e.cyc = c; e.addr = a; e.bank = b;
        rd_q.push_back(e);
    endtask

    task automatic expect_fetch(input logic [10:0] a, input logic bank, input int t0);
        push_rd(t0 + 2, {1'b0, a, 1'b0}, bank);
        push_rd(t0 + 3, {1'b0, a, 1'b1}, bank);
        done_q.push_back(t0 + 5);
    endtask

    // Shift out all 8 slots; one hex nibble per slot, slot 0 leftmost.
    task automatic readout(input string tag, input logic [31:0] pv, input logic [31:0] gv,
                           input logic [7:0] dv, input logic [7:0] rv);
        shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_pix($sformatf("%s_slot%0d", tag, i), pv[28-4*i +: 2], gv[28-4*i +: 3], dv[7-i], rv[7-i]);
            tick();
        end
        shift = 1'b0;
    endtask

    task automatic do_fetch(input logic [10:0] a, input logic [7:0] at, input logic [7:0] lo,
                            input logic [7:0] hi, input logic gbc, input logic hold_shift,
                            input pix_exp_t hold_exp);
        int t0;
        vram[{1'b0, a, 1'b0}] = lo;
        vram[{1'b0, a, 1'b1}] = hi;
        isGBC       = gbc;
        sprite_addr = a;
        sprite_attr = at;
        t0          = cyc;
        expect_fetch(a, gbc & at[3], t0);
        sprite_fetch = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) sprite_fetch = 1'b0;
            if (hold_shift) begin
                shift = 1'b1;
                pix_q.push_back(hold_exp);
            end
            tick();
        end
        shift = 1'b0;
    endtask

    initial begin : stimulus
        pix_exp_t none;
        pix_exp_t hold;
        int       t0;
        none.tag = "none"; none.pix = 2'd0; none.gbc = 3'd0; none.dmg = 1'b0; none.prio = 1'b0;
        reset = 1'b1; ce = 1'b1; isGBC = 1'b0; line_clear = 1'b0;
        sprite_fetch = 1'b0; shift = 1'b0; sprite_addr = '0; sprite_attr = '0;
        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;

        // Reset state
        repeat (2) tick();
        probe_tag = "reset_outputs"; probe = 1'b1;
        tick();
        probe = 1'b0; reset = 1'b0;
        tick();
        push_pix("reset_slot0", 2'd0, 3'd0, 1'b0, 1'b0);
        shift = 1'b1; tick(); shift = 1'b0;

        // Basic fetch: lo=F0, hi=AA, no flip
        do_fetch(11'h123, 8'h00, 8'hF0, 8'hAA, 1'b0, 1'b0, none);
        readout("basic", 32'h3131_2020, 32'h0, 8'h00, 8'h00);

        // X-flip + GBC bank/palette, with ce running at half rate
        ce_alt = 1'b1;
        do_fetch(11'h123, 8'h2D, 8'hF0, 8'hAA, 1'b1, 1'b0, none);
        readout("xflip", 32'h0202_1313, 32'h0505_5555, 8'h00, 8'h00);
        ce_alt = 1'b0;
        isGBC  = 1'b0;

        // Overlap: earlier sprite keeps every slot; shift during the fetch is ignored
        do_fetch(11'h040, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b0, none);
        hold.tag = "hold_shift"; hold.pix = 2'd1; hold.gbc = 3'd0; hold.dmg = 1'b1; hold.prio = 1'b0;
        do_fetch(11'h050, 8'h08, 8'h00, 8'hFF, 1'b0, 1'b1, hold);
        readout("overlap", 32'h1111_1111, 32'h0, 8'hFF, 8'h00);

        // Partial merge: only the rightmost pixel is opaque
        do_fetch(11'h060, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, none);
        readout("partial", 32'h0000_0001, 32'h0, 8'h00, 8'h00);
        push_pix("partial_after", 2'd0, 3'd0, 1'b0, 1'b0);
        shift = 1'b1; tick(); shift = 1'b0;

        // Back-to-back: sprite_fetch held across DONE
        vram[13'h0020] = 8'hFF;
        vram[13'h0021] = 8'hFF;
        isGBC = 1'b0; sprite_addr = 11'h123; sprite_attr = 8'h00;
        t0 = cyc;
        expect_fetch(11'h123, 1'b0, t0);
        expect_fetch(11'h010, 1'b0, t0 + 6);
        sprite_fetch = 1'b1;
        repeat (6) tick();
        sprite_addr = 11'h010; sprite_attr = 8'h80;
        repeat (5) tick();
        sprite_fetch = 1'b0;
        tick();
        readout("b2b", 32'h3131_2323, 32'h0, 8'h00, 8'b0000_0101);

        // Abort by line_clear during RD_HI flushes the shifter
        do_fetch(11'h123, 8'h00, 8'hF0, 8'hAA, 1'b0, 1'b0, none);
        sprite_addr = 11'h123; sprite_attr = 8'h00;
        t0 = cyc;
        push_rd(t0 + 2, 13'h0246, 1'b0);
        push_rd(t0 + 3, 13'h0247, 1'b0);
        sprite_fetch = 1'b1;
        repeat (3) tick();
        line_clear = 1'b1;
        tick();
        line_clear = 1'b0; sprite_fetch = 1'b0;
        probe_tag = "line_clear_outputs"; probe = 1'b1;
        tick();
        probe = 1'b0;
        readout("line_clear", 32'h0, 32'h0, 8'h00, 8'h00);

        // sprite_fetch drops during WAIT: no reads, no done, no merge
        sprite_fetch = 1'b1;
        tick();
        sprite_fetch = 1'b0;
        repeat (6) tick();
        readout("wait_drop", 32'h0, 32'h0, 8'h00, 8'h00);

        // Reset during RD_LO clears everything
        do_fetch(11'h123, 8'h00, 8'hF0, 8'hAA, 1'b0, 1'b0, none);
        t0 = cyc;
        push_rd(t0 + 2, 13'h0246, 1'b0);
        sprite_fetch = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; sprite_fetch = 1'b0;
        probe_tag = "reset_midfetch_outputs"; probe = 1'b1;
        tick();
        probe = 1'b0;
        readout("reset_mid", 32'h0, 32'h0, 8'h00, 8'h00);

        repeat (3) tick();
        finish_req = 1'b1;
        tick();
        tick();
    end

endmodule

// File: doc/sprite_pixel_fetcher.md
Name: sprite_pixel_fetcher

Overview:
- Sits directly downstream of the OAM scan/sprite-select stage in the video pipeline.
- When that stage raises sprite_fetch with a tile row address and attributes, this block:
  - reads the two bitplane bytes from VRAM,
  - applies X-flip,
  - merges the 8 pixels into an 8-slot sprite pixel shifter,
  - pulses sprite_fetch_done back upstream.
- The shifter supplies one sprite pixel per shift to the BG/sprite mixer.

Parameters:
- TILE_BASE, 13'h0000, VRAM byte offset of sprite tile data. Sprite tiles always start at 0x8000.
- ATTR_WAIT, 2, ce cycles the upstream stage needs after sprite_fetch rises before tile/row/attributes are stable.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  pixel-rate clock enable; all state advances only when ce=1
- isGBC  in  1  selects GBC attribute handling (VRAM bank, 3-bit palette)
- line_clear  in  1  start of line / LCD off; flushes shifter, aborts fetch
- sprite_fetch  in  1  upstream request, held high until done is seen
- sprite_addr  in  11  {tile,row[2:0]} from upstream; valid from ATTR_WAIT on
- sprite_attr  in  8  OAM attribute byte; valid from ATTR_WAIT on
- sprite_fetch_done  out  1  one-ce-cycle completion pulse to upstream
- vram_rd  out  1  VRAM read strobe
- vram_addr  out  13  VRAM byte address
- vram_bank  out  1  VRAM bank; sprite_attr[3] when isGBC, else 0
- vram_data  in  8  read data, valid on the ce cycle after vram_rd
- shift  in  1  advance shifter one pixel (honoured only in IDLE)
- spr_pix  out  2  colour index of slot 0 (0 = transparent)
- spr_pal_gbc  out  3  GBC palette of slot 0
- spr_pal_dmg  out  1  DMG OBP select of slot 0
- spr_bg_prio  out  1  BG-over-OBJ flag of slot 0

Behaviour:
- Reset / line_clear (reset wins if both):
  - FSM to IDLE.
  - All 8 slots zeroed, so all pixel outputs are 0.
  - sprite_fetch_done=0, vram_rd=0, vram_addr=0, vram_bank=0.
  - line_clear mid-fetch abandons the fetch with no done pulse.
- FSM states, all transitions on ce:
  - IDLE: if sprite_fetch=1, go to WAIT with cnt=0.
  - WAIT: cnt++; at cnt==ATTR_WAIT-1, latch sprite_attr into attr_q and sprite_addr into addr_q, then go to RD_LO.
  - RD_LO: vram_rd=1, vram_addr=TILE_BASE+{addr_q,1'b0}; go to RD_HI.
  - RD_HI: capture lo<=vram_data; vram_rd=1, vram_addr=TILE_BASE+{addr_q,1'b1}; go to MERGE.
  - MERGE: capture hi<=vram_data, go to DONE.
  - DONE: apply merge; sprite_fetch_done=1 for exactly this ce cycle; go to IDLE.
- sprite_fetch dropping before DONE returns the FSM to IDLE with no merge and no done pulse.
- After DONE the FSM spends at least one ce cycle in IDLE. A still-high sprite_fetch (a second sprite at the same X) then restarts at WAIT cnt=0.
- Latency: sprite_fetch rise at ce cycle T gives done at T+ATTR_WAIT+3, which is T+5 at default.
- vram_bank = isGBC & attr_q[3] during RD_LO/RD_HI, else 0.
- Pixel extraction, for slot i (0 = leftmost):
  - bit b = attr_q[5] ? i : 7-i;
  - pixel = {hi[b],lo[b]}.
- Merge rule: slot i takes the new pixel+attrs only if its current pix==0 and the new pix!=0.
  - Sprites fetched earlier keep precedence on overlap.
  - A transparent new pixel never overwrites a slot.
- Slot attrs on merge: pal_gbc=attr_q[2:0], pal_dmg=attr_q[4], bg_prio=attr_q[7].
- Shift: in IDLE with ce&shift, slots move down one (slot0 drops out) and slot7 is zeroed. shift in any other state is ignored and the shifter holds.
- Outputs are combinational from slot 0.
- When ce=0, nothing changes and vram_rd still reflects the state.

Decomposition:
- Shared package gb_sprite_pkg:
  - fetch state enum (IDLE, WAIT, RD_LO, RD_HI, MERGE, DONE);
  - slot type {pix[1:0], pal_gbc[2:0], pal_dmg, bg_prio};
  - SLOT_COUNT=8.
- One combinational sub-module, sprite_row_merge:
  - inputs: current 8 slots, lo, hi, attr;
  - output: merged 8 slots;
  - performs flip and transparency merge.

Test Plan:
- Basic fetch:
  - Stimulus: sprite_fetch held, sprite_addr=11'h123, attr=8'h00, VRAM[0x246]=8'hF0, [0x247]=8'hAA.
  - Response: done at T+5; slots 0..7 pix = 3,1,3,1,2,0,2,0.
- X-flip and GBC:
  - Stimulus: same data, attr=8'h2D, isGBC=1.
  - Response: vram_bank=1 on both reads; slot order reversed (0,2,0,2,1,3,1,3); pal_gbc=5 and pal_dmg=0 on opaque slots.
- Overlap priority:
  - Stimulus: first fetch lo=8'hFF,hi=00 with attr[4]=1; second fetch lo=00,hi=FF with attr[4]=0, no shift between.
  - Response: all slots keep pix=1 and pal_dmg=1.
- Shift after partial merge:
  - Stimulus: lo=8'h01,hi=00, then 7 shifts.
  - Response: spr_pix=1 only after the 7th shift; the next shift gives 0.
- Abort:
  - Stimulus: line_clear asserted in RD_HI.
  - Response: IDLE next ce, no done pulse, all outputs 0. Same result when sprite_fetch drops during WAIT.
- Back-to-back:
  - Stimulus: sprite_fetch stays high across DONE.
  - Response: one IDLE cycle, then a second complete fetch with done at +6 from the first done.
